std_div_seq: RTL and testbench



---
 rtl/std_div_pkg.sv | 11 +
 rtl/std_div_step.sv | 24 ++
 rtl/std_div_seq.sv | 93 +++++++++
 tb/tb_std_div_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/std_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package std_div_pkg;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    // Step counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/std_div_step.sv
// One restoring-division step: shift {rem, dvd} left, trial-subtract, restore on borrow.
module std_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_dvd
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;

    // Extra top bit makes the trial result's sign a clean borrow flag.
    assign w_shift  = {i_rem, i_dvd[WIDTH-1]};
    assign w_trial  = w_shift - {2'b00, i_divisor};
    assign w_borrow = w_trial[WIDTH+1];

    assign o_rem = w_borrow ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
    assign o_dvd = {i_dvd[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/std_div_seq.sv
// Iterative unsigned divider: one restoring step per cycle, go/done handshake,
// registered quotient/remainder that hold until the next completion.
module std_div_seq
    import std_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);

    localparam int CW = div_cnt_w(WIDTH);

    div_state_t       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rmd;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic             w_last;

    std_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_dvd     (r_dvd),
        .i_divisor (r_dsr),
        .o_rem     (w_rem_nxt),
        .o_dvd     (w_dvd_nxt)
    );

    assign w_last = (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= DIV_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (go) w_state_nxt = DIV_BUSY;
            DIV_BUSY: if (w_last) w_state_nxt = DIV_DONE;
            DIV_DONE: w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= '0;
            r_dsr <= '0;
            r_quo <= '0;
            r_rmd <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (go) begin
                        r_dsr <= right;
                        r_dvd <= left;
                        r_rem <= '0;
                        r_cnt <= CW'(WIDTH);
                    end
                end
                DIV_BUSY: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_dvd_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    // Results are captured from the final step's outputs directly.
                    if (w_last) begin
                        r_quo <= w_dvd_nxt;
                        r_rmd <= w_rem_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_quotient  = r_quo;
    assign out_remainder = r_rmd;
    assign done          = (r_state == DIV_DONE);

endmodule

// File: tb/tb_std_div_seq.sv
// Scoreboard bench for std_div_seq at WIDTH=8.
module tb_std_div_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           t0;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         go = 1'b0;
    logic [W-1:0] left = '0;
    logic [W-1:0] right = '0;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         done;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_done = 0;
    bit   prev_done = 1'b0;

    std_div_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .done          (done)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference results from native / and % operators.
    function automatic exp_t make_exp(input logic [W-1:0] l, input logic [W-1:0] r, input int t0);
        exp_t e;
        if (r == 0) begin
            e.q = '1;
            e.r = l;
        end else begin
            e.q = l / r;
            e.r = l % r;
        end
        e.t0 = t0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                exp_t e;
                n_done++;
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_pulse: done high two cycles at cyc %0d", cyc);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: done at cyc %0d with no outstanding division", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (out_quotient !== e.q || out_remainder !== e.r) begin
                        errors++;
                        $display("FAIL result: got q=%0d r=%0d, expected q=%0d r=%0d", out_quotient, out_remainder, e.q, e.r);
                    end
                    checks++;
                    if (cyc - e.t0 !== W) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, expected %0d", cyc - e.t0, W);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done within 40 cycles, expected one");
        end
    endtask

    task automatic do_div(input logic [W-1:0] l, input logic [W-1:0] r);
        @(negedge clk);
        left = l;
        right = r;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        sb.push_back(make_exp(l, r, cyc));
        n_acc++;
        wait_done();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_quotient !== 0 || out_remainder !== 0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got q=%0d r=%0d done=%0b, expected 0 0 0", out_quotient, out_remainder, done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_div(8'd100, 8'd7);
        do_div(8'd5, 8'd0);
        do_div(8'd0, 8'd9);
        do_div(8'd255, 8'd255);
        do_div(8'd254, 8'd255);
    endtask

    task automatic test_back_to_back();
        int t;
        @(negedge clk);
        left = 8'd3;
        right = 8'd10;
        go = 1'b1;
        @(negedge clk);
        t = cyc;
        sb.push_back(make_exp(8'd3, 8'd10, t));
        sb.push_back(make_exp(8'd255, 8'd1, t + W + 2));
        n_acc += 2;
        left = 8'd255;
        right = 8'd1;
        wait_done();
        repeat (2) @(negedge clk);
        go = 1'b0;
        wait_done();
        @(negedge clk);
    endtask

    task automatic test_ignore_go();
        @(negedge clk);
        left = 8'd100;
        right = 8'd7;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        sb.push_back(make_exp(8'd100, 8'd7, cyc));
        n_acc++;
        repeat (3) @(negedge clk);
        left = 8'd200;
        right = 8'd3;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        left = 8'd0;
        wait_done();
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_quotient !== 8'd14 || out_remainder !== 8'd2 || done !== 1'b0) begin
                errors++;
                $display("FAIL hold: got q=%0d r=%0d done=%0b, expected 14 2 0", out_quotient, out_remainder, done);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        left = 8'd100;
        right = 8'd7;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_quotient !== 0 || out_remainder !== 0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got q=%0d r=%0d done=%0b, expected 0 0 0", out_quotient, out_remainder, done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_quotient !== 0) begin
                errors++;
                $display("FAIL aborted_div: got done=%0b q=%0d, expected 0 0", done, out_quotient);
            end
        end
        do_div(8'd100, 8'd7);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            do_div(8'($urandom_range(255, 0)), 8'($urandom_range(255, 1)));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_go();
        test_reset_mid_busy();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (n_done !== n_acc || sb.size() != 0) begin
            errors++;
            $display("FAIL done_count: got %0d dones (%0d pending), expected %0d", n_done, sb.size(), n_acc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
